// File: rtl/flash_reader_pkg.sv
// ============================================================
// Module : flash_reader_pkg
// Brief  : Shared constants and state encodings for flash_reader.
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

package flash_reader_pkg;

  localparam logic [15:0] c_flash_cmd_read_array = 16'h00FF;

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_cmd  = 3'd1;
  localparam logic [2:0] c_st_gap  = 3'd2;
  localparam logic [2:0] c_st_read = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

endpackage

`default_nettype wire

// File: rtl/flash_reader_dq_buf.sv
// ============================================================
// Module : flash_reader_dq_buf
// Brief  : Tristate buffer for the flash data bus.
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module flash_reader_dq_buf #(
  parameter int DATA_W = 16
) (
  input  logic              drive,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  inout  wire  [DATA_W-1:0] dq
);

  assign dq      = drive ? wr_data : {DATA_W{1'bz}};
  assign rd_data = dq;

endmodule

`default_nettype wire

// File: rtl/flash_reader.sv
// ============================================================
// Module : flash_reader
// Brief  : NOR flash word read controller: read-array command, then async
//          read. Define FLASH_READ_ARRAY_ONCE_EN to issue the command only once.
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] flash_addr,
  inout  wire  [DATA_W-1:0] flash_dq,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              flash_byte_n,
  output logic              flash_vpen,
  output logic              flash_rp_n
);

  localparam logic [3:0] c_cnt_reload = 4'(WAIT_CYCLES - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_flash_addr;
  logic [DATA_W-1:0] r_data_out;
  logic              w_dq_oe;
  logic [DATA_W-1:0] w_dq_in;
  logic              w_skip_cmd;

`ifdef FLASH_READ_ARRAY_ONCE_EN
  logic r_armed;

  // Device stays in read-array mode once commanded, so later reads skip CMD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (r_state == c_st_cmd && w_state_next == c_st_gap) begin
      r_armed <= 1'b1;
    end
  end

  assign w_skip_cmd = r_armed;
`else
  assign w_skip_cmd = 1'b0;
`endif

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_cnt        <= '0;
      r_flash_addr <= '0;
      r_data_out   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= c_cnt_reload;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == c_st_idle && req) begin
        r_flash_addr <= addr;
      end
      if (r_state == c_st_read && r_cnt == '0) begin
        r_data_out <= w_dq_in;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (req) w_state_next = w_skip_cmd ? c_st_read : c_st_cmd;
      c_st_cmd:  if (r_cnt == '0) w_state_next = c_st_gap;
      c_st_gap:  w_state_next = c_st_read;
      c_st_read: if (r_cnt == '0) w_state_next = c_st_done;
      c_st_done: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    flash_ce_n = 1'b1;
    flash_we_n = 1'b1;
    flash_oe_n = 1'b1;
    w_dq_oe    = 1'b0;
    done       = 1'b0;
    busy       = (r_state != c_st_idle);
    case (r_state)
      c_st_cmd: begin
        flash_ce_n = 1'b0;
        flash_we_n = 1'b0;
        w_dq_oe    = 1'b1;
      end
      c_st_gap:  flash_ce_n = 1'b0;
      c_st_read: begin
        flash_ce_n = 1'b0;
        flash_oe_n = 1'b0;
      end
      c_st_done: done = 1'b1;
      default: ;
    endcase
  end

  flash_reader_dq_buf #(
    .DATA_W (DATA_W)
  ) u_dq_buf (
    .drive   (w_dq_oe),
    .wr_data (DATA_W'(c_flash_cmd_read_array)),
    .rd_data (w_dq_in),
    .dq      (flash_dq)
  );

  assign data_out     = r_data_out;
  assign flash_addr   = r_flash_addr;
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b1;
  assign flash_rp_n   = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_flash_reader.sv
// ============================================================
// Module : tb_flash_reader
// Brief  : Randomized scoreboard bench for flash_reader with a flash model.
// Rev    : 1.0  initial release
// ============================================================
`default_nettype none

module tb_flash_reader;

  localparam int W = 4;
`ifdef FLASH_READ_ARRAY_ONCE_EN
  localparam bit ONCE = 1'b1;
`else
  localparam bit ONCE = 1'b0;
`endif

  typedef struct {
    logic [21:0] addr;
    logic [15:0] data;
    int          lat;
    int          we;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [21:0] addr;
  logic [15:0] data_out;
  logic        done;
  logic        busy;
  logic [21:0] flash_addr;
  wire  [15:0] flash_dq;
  logic        flash_ce_n, flash_oe_n, flash_we_n;
  logic        flash_byte_n, flash_vpen, flash_rp_n;

  logic [15:0] mem [256];
  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          armed = 1'b0;

  flash_reader dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .addr         (addr),
    .data_out     (data_out),
    .done         (done),
    .busy         (busy),
    .flash_addr   (flash_addr),
    .flash_dq     (flash_dq),
    .flash_ce_n   (flash_ce_n),
    .flash_oe_n   (flash_oe_n),
    .flash_we_n   (flash_we_n),
    .flash_byte_n (flash_byte_n),
    .flash_vpen   (flash_vpen),
    .flash_rp_n   (flash_rp_n)
  );

  // Asynchronous flash: drives the addressed word while ce_n and oe_n are low
  assign flash_dq = (!flash_ce_n && !flash_oe_n) ? mem[flash_addr[7:0]] : 16'hzzzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_idle_pins(input string tag);
    chk({tag, "_ce_n"}, 32'(flash_ce_n), 32'd1);
    chk({tag, "_oe_n"}, 32'(flash_oe_n), 32'd1);
    chk({tag, "_we_n"}, 32'(flash_we_n), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_flash_addr"}, 32'(flash_addr), 32'd0);
    chk({tag, "_const_pins"}, {29'd0, flash_byte_n, flash_vpen, flash_rp_n}, 32'd7);
  endtask

  // One transaction: idle cycles, accept, then junk on req/addr while busy.
  // rst_at > 0 asserts reset in that cycle after accept instead of completing.
  task automatic txn(input logic [21:0] a, input logic [15:0] w, input int idle,
                     input bit hold, input int rst_at);
    exp_t e;
    int   n;
    repeat (idle) begin
      @(negedge clk); req = 1'b0; addr = 22'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    mem[a[7:0]] = w;
    req  = 1'b1;
    addr = a;
    e.addr = a;
    e.data = w;
    e.lat  = (ONCE && armed) ? W + 1 : 2 * W + 2;
    e.we   = (ONCE && armed) ? 0 : W;
    armed  = 1'b1;
    @(posedge clk);
    n = (rst_at > 0) ? rst_at : e.lat;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        e.acc = cyc - 1;
        q.push_back(e);
      end
      if (rst_at > 0 && k == rst_at) rst = 1'b1;
      req  = hold ? 1'b1 : 1'($urandom);
      addr = 22'($urandom);
      @(posedge clk);
    end
    if (rst_at > 0) begin
      @(negedge clk);
      chk_idle_pins("midreset");
      q.delete();
      armed = 1'b0;
      req = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard compare on done
  int we_cnt = 0, oe_cnt = 0;
  bit cmd_bad = 0, ce_bad = 0, prev_done = 0;
  always @(negedge clk) begin
    if (rst) begin
      we_cnt = 0; oe_cnt = 0; cmd_bad = 0; ce_bad = 0; prev_done = 0;
    end else begin
      chk("we_oe_overlap", 32'(!flash_we_n && !flash_oe_n), 32'd0);
      if (!flash_we_n) begin
        we_cnt++;
        if (flash_dq !== 16'h00FF || flash_ce_n) cmd_bad = 1;
      end
      if (!flash_oe_n) begin
        oe_cnt++;
        if (flash_ce_n) ce_bad = 1;
      end
      if (prev_done) begin
        chk("done_width", 32'(done), 32'd0);
        chk("dead_cycle_busy", 32'(busy), 32'd0);
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("data_out", 32'(data_out), 32'(mon_e.data));
          chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          chk("flash_addr", 32'(flash_addr), 32'(mon_e.addr));
          chk("we_cycles", 32'(we_cnt), 32'(mon_e.we));
          chk("oe_cycles", 32'(oe_cnt), 32'(W));
          chk("cmd_word_ce", 32'(cmd_bad), 32'd0);
          chk("read_ce", 32'(ce_bad), 32'd0);
          chk("busy_at_done", 32'(busy), 32'd1);
          chk("strobes_at_done", {29'd0, flash_ce_n, flash_oe_n, flash_we_n}, 32'd7);
        end
        we_cnt = 0; oe_cnt = 0; cmd_bad = 0; ce_bad = 0;
      end
      prev_done = done;
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_pins("reset");
    rst = 1'b0;
    @(posedge clk);

    // Reset during READ of the first (commanded) read
    txn(22'h000055, 16'h1234, 0, 1'b0, ONCE ? 2 * W - 1 : 2 * W - 1);
    // Directed read
    txn(22'h000123, 16'hBEEF, 0, 1'b0, 0);
    // Back-to-back with req held high
    txn(22'h000001, 16'h1111, 0, 1'b1, 0);
    txn(22'h000002, 16'h2222, 0, 1'b1, 0);
    // Address wiggles while busy must be ignored
    txn(22'h000010, 16'h3333, 1, 1'b0, 0);
    for (int i = 0; i < 25; i++)
      txn(22'($urandom), 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 0);
    // Reset mid-read, then the next read must start from a fresh command
    txn(22'h000077, 16'h5A5A, 0, 1'b0, 2);
    txn(22'h0000AA, 16'hC3C3, 0, 1'b0, 0);
    txn(22'($urandom), 16'($urandom), 0, 1'b1, 0);

    @(negedge clk); req = 1'b0;
    repeat (2 * W + 6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
